// File: rtl/ioctl_upload_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ioctl_upload_reader_if : HPS upload handshake, cart RAM port and stats   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface ioctl_upload_reader_if #(
  parameter int ADDR_W = 16
);
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              ram_grant;
  logic              busy;
  logic [15:0]       bytes_sent;
  logic [7:0]        checksum;
  logic              overrun;
  logic              done;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, ram_q, ram_grant,
    input  ioctl_din, ioctl_wait, ram_addr, ram_rd, busy, bytes_sent,
           checksum, overrun, done
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, ram_q, ram_grant,
    output ioctl_din, ioctl_wait, ram_addr, ram_rd, busy, bytes_sent,
           checksum, overrun, done
  );
endinterface
`default_nettype wire

// File: rtl/ioctl_upload_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ioctl_upload_reader : serves HPS save-upload reads from cart extra RAM   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ioctl_upload_reader #(
  parameter int ADDR_W      = 16,
  parameter int SIZE        = 128,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  ioctl_upload_reader_if.slave  bus
);
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_REQ    = 2'd1;
  localparam logic [1:0]  S_LAT    = 2'd2;
  localparam logic [1:0]  S_FIN    = 2'd3;
  localparam logic [1:0]  LAT_INIT = 2'(RAM_LATENCY - 1);
  localparam logic [24:0] SIZE_C   = 25'(SIZE);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       bytes_q, bytes_d;
  logic [7:0]        csum_q, csum_d;
  logic              overrun_q, overrun_d;
  logic              done_q, done_d;
  logic              upload_q;

  logic w_accept, w_start, w_end;

  assign w_start  = bus.ioctl_upload & ~upload_q;
  assign w_end    = ~bus.ioctl_upload & upload_q;
  assign w_accept = (state_q == S_IDLE) & bus.ioctl_rd & bus.ioctl_upload;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    bytes_d   = bytes_q;
    csum_d    = csum_q;
    overrun_d = overrun_q;
    done_d    = w_end;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          addr_d = bus.ioctl_addr[ADDR_W-1:0];
          if (bus.ioctl_addr < SIZE_C) begin
            state_d = S_REQ;
          end else begin
            din_d   = 8'hFF;
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        if (bus.ram_grant) begin
          cnt_d   = LAT_INIT;
          state_d = S_LAT;
        end
      end
      S_LAT: begin
        if (cnt_q == 2'd0) begin
          din_d   = bus.ram_q;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_FIN: begin
        if (bytes_q != 16'hFFFF) begin
          bytes_d = bytes_q + 16'd1;
        end
        csum_d  = csum_q + din_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.ioctl_rd && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Upload dropping mid-fetch abandons the byte: nothing captured or counted.
    if (w_end && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      din_d   = din_q;
      bytes_d = bytes_q;
      csum_d  = csum_q;
    end

    // Session clear takes priority over a FIN retiring in the same cycle.
    if (w_start) begin
      bytes_d   = 16'd0;
      csum_d    = 8'd0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      din_q     <= 8'h00;
      cnt_q     <= 2'd0;
      bytes_q   <= 16'd0;
      csum_q    <= 8'd0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      upload_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
      bytes_q   <= bytes_d;
      csum_q    <= csum_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      upload_q  <= bus.ioctl_upload;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = (state_q != S_IDLE) | w_accept;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_rd     = (state_q == S_REQ) & bus.ram_grant;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.bytes_sent = bytes_q;
  assign bus.checksum   = csum_q;
  assign bus.overrun    = overrun_q;
  assign bus.done       = done_q;
endmodule
`default_nettype wire

// File: doc/ioctl_upload_reader.md
Name: ioctl_upload_reader

Overview:
- Serves HPS save-upload read requests (ioctl_rd/ioctl_addr) from an on-chip cartridge RAM (SuperChip extra RAM) and returns bytes on ioctl_din. Uses the ioctl_wait handshake.
- Upload-direction counterpart of the ROM download path. Sits between hps_io and the read port of the cart RAM dpram.
- Shares the RAM read port with the core through a grant signal. Keeps byte-count and checksum statistics per upload session.

Parameters:
- ADDR_W, 16, width of ram_addr.
- SIZE, 128, number of valid RAM bytes; addresses >= SIZE read as 8'hFF without a RAM access.
- RAM_LATENCY, 1, clocks from ram_rd to valid ram_q (1..4).

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload session active (level from hps_io).
- ioctl_rd  in  1  one-cycle read request strobe from HPS.
- ioctl_addr  in  25  byte address of request, sampled with ioctl_rd.
- ioctl_din  out  8  returned byte; valid when ioctl_wait is low after a request.
- ioctl_wait  out  1  high while a request is being serviced.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd  out  1  RAM read strobe, one cycle.
- ram_q  in  8  RAM read data.
- ram_grant  in  1  core releases the RAM port this cycle.
- busy  out  1  state != IDLE.
- bytes_sent  out  16  bytes served in current session.
- checksum  out  8  mod-256 sum of bytes served in current session.
- overrun  out  1  sticky; ioctl_rd seen while busy.
- done  out  1  one-cycle pulse at end of session.

Behaviour:
- Reset values: all outputs 0, ioctl_din 8'h00, state IDLE. Reset mid-fetch aborts the fetch immediately and updates no counter.
- States: IDLE, REQ, LAT, FIN.
- IDLE + ioctl_rd + ioctl_upload:
  - Latch ioctl_addr.
  - If addr < SIZE, go to REQ.
  - Otherwise load ioctl_din = 8'hFF and go to FIN.
- ioctl_rd while ioctl_upload is low: ignored.
- REQ:
  - Drive ram_addr = latched addr[ADDR_W-1:0].
  - When ram_grant = 1, pulse ram_rd for one cycle, load the latency counter with RAM_LATENCY-1, go to LAT.
  - With ram_grant = 0, stay in REQ indefinitely.
- LAT: when the counter is 0, capture ram_q into ioctl_din and go to FIN; otherwise decrement. ram_q is sampled exactly RAM_LATENCY cycles after the ram_rd cycle.
- FIN: bytes_sent += 1 (saturate at 16'hFFFF), checksum += ioctl_din (wraps mod 256), go to IDLE.
- ioctl_wait = (state != IDLE) | (ioctl_rd & ioctl_upload & state == IDLE).
  - Combinational, so it is high in the same cycle as the accepted strobe.
  - It drops in the cycle after FIN.
- Minimum request latency, with grant already high and RAM_LATENCY = 1: strobe at cycle 0, wait low at cycle 4 (REQ c1, LAT c2, FIN c3, IDLE c4).
- ioctl_din holds its value until the next capture.
- ioctl_rd while state != IDLE: request dropped, overrun <= 1. overrun clears only on reset or a session start.
- Session start (rising edge of ioctl_upload, registered): bytes_sent <= 0, checksum <= 0, overrun <= 0.
- Session end (falling edge of ioctl_upload): done pulses for one cycle.
  - If a fetch is in progress, it aborts to IDLE: no counter update, ioctl_din unchanged.
  - done still pulses.
- Simultaneous FIN and session start (edge registered in the same cycle): the session clear wins, and the counters end at 0.

Test Plan:
- RAM holds i^8'h5A at addr i, grant tied 1, LATENCY=1, upload addr 0..127 -> ioctl_din[i] = i^8'h5A, wait high exactly 4 cycles per byte, bytes_sent = 128, checksum = mod-256 sum of i^8'h5A, done one pulse after upload falls.
- Request addr 200 (SIZE=128) -> ioctl_din = 8'hFF, ram_rd never asserted, wait high 2 cycles, bytes_sent +1, checksum +8'hFF.
- ram_grant held 0 for 10 cycles after the strobe -> ram_rd stays 0 and wait stays high throughout; grant=1 -> read completes 3 cycles later with the correct byte.
- RAM_LATENCY=3, addr 5 holding 8'hC3 -> ram_q sampled 3 cycles after ram_rd, ioctl_din = 8'hC3, wait high 6 cycles.
- Second ioctl_rd issued while in LAT -> overrun = 1, only the first byte counted; new upload session -> overrun = 0, counters = 0.
- Upload drops or reset asserted while in LAT -> state IDLE next cycle, counters unchanged (reset: all 0), ioctl_wait = 0; done pulses only on the upload drop.
